program_loader: RTL
===================

// Module: program_loader
// PURPOSE
// - Upstream feeder of microprocessor_top. Receives a byte stream (sync, length, payload, checksum),
//   packs little-endian 32-bit words and writes them into instruction memory via w_en/instruction.
// - Asserts prog_ready once a complete, checksum-verified image is loaded; the core runs only then.
// PARAMETERS
// - DATA_WIDTH      32       instruction/word width; fixed at 32 (4 bytes per word)
// - MEM_DEPTH       64       instruction memory depth in words; max accepted word count
// - TIMEOUT_CYCLES  1024     max clk cycles between accepted bytes once a frame has started
// PORTS
// - clk          in   1           single clock, all logic on posedge
// - rst          in   1           synchronous, active-high reset
// - rx_data      in   8           incoming byte
// - rx_valid     in   1           rx_data valid
// - rx_ready     out  1           loader can accept a byte
// - w_en         out  1           instruction memory write strobe, one cycle per word
// - w_addr       out  DATA_WIDTH  byte address of write (word index * 4)
// - instruction  out  DATA_WIDTH  write data to instruction memory
// - prog_ready   out  1           valid image loaded; core may execute
// - load_error   out  1           last frame failed (bad length, checksum, timeout)
// - busy         out  1           frame in progress (any state except IDLE/DONE/ERROR)
// BEHAVIOUR
// - Reset: state IDLE; w_en=0, w_addr=0, instruction=0, prog_ready=0, load_error=0, busy=0; counters 0.
// - Byte transfer on posedge with rx_valid && rx_ready. rx_ready decoded from registered state only.
// - Frame: SYNC 0xA5 | LEN_LO | LEN_HI | LEN*4 payload bytes (LSB first per word) | CHK.
//   CHK = XOR of all payload bytes (length and sync excluded).
// - FSM:
//   IDLE: rx_ready=1; 0xA5 -> LEN_LO; other bytes discarded.
//   LEN_LO, LEN_HI: rx_ready=1; latch 16-bit word count. After LEN_HI: count==0 or count>MEM_DEPTH -> ERROR,
//     else DATA; word index=0, byte index=0, checksum=0.
//   DATA: rx_ready=1; shift byte into word at position byte index; XOR into checksum; 4th byte -> WRITE.
//   WRITE: rx_ready=0; w_en=1 exactly this cycle, w_addr=index*4, instruction=assembled word.
//     Next: index+1==count -> CHECK, else DATA. Write latency: 1 cycle after 4th byte accepted.
//   CHECK: rx_ready=1; byte==checksum -> DONE, else ERROR.
//   DONE: prog_ready=1, load_error=0; rx_ready=1; 0xA5 -> LEN_LO with prog_ready dropping next cycle.
//   ERROR: load_error=1, prog_ready=0; rx_ready=1; 0xA5 -> LEN_LO and load_error clears.
// - Timeout: counter runs in LEN_LO/LEN_HI/DATA/CHECK, clears on each accepted byte;
//   reaching TIMEOUT_CYCLES -> ERROR. Never runs in IDLE/DONE/ERROR/WRITE.
// - w_en is 0 outside WRITE; w_addr/instruction hold last written values otherwise.
// - Reset mid-frame: returns to IDLE, prog_ready=0; already-written memory words are not cleared.
// - Reload in DONE: prog_ready low for whole new frame; partial overwrite of image is permitted.
// - 16-bit length compared before truncation; counters sized $clog2(MEM_DEPTH+1).
// STRUCTURE
// - Shared package: loader_state_t enum (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR),
//   SYNC_BYTE=8'hA5 localparam; DATA_WIDTH comes from the existing defines.
// - One sub-module: word_assembler (byte shift-in, byte index, XOR checksum, clear/load strobes).
// TESTING
// - Frame A5,02,00, 13,05,10,00, 33,06,B5,00, CHK=XOR -> w_en twice: addr 0 = 0x00100513,
//   addr 4 = 0x00B50633; prog_ready=1 cycle after CHK accepted.
// - Same frame, CHK xor 0x01 -> load_error=1, prog_ready=0, no further w_en.
// - LEN = 0x0000 and LEN = MEM_DEPTH+1 -> ERROR after LEN_HI, zero w_en pulses.
// - Stall 1024 cycles mid-DATA after 2 bytes -> load_error=1 at the timeout cycle; then a valid frame -> DONE.
// - rst pulsed after 1st word written -> all outputs 0, state IDLE; next valid frame loads normally.
// - Random rx_valid gaps (<TIMEOUT): rx_ready=0 exactly on WRITE cycles; byte count and word contents match a reference model.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader slice.
//   loader_state_t : frame-parser state encoding
//   SYNC_BYTE      : first byte of every load frame
package program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
//   rx_data/rx_valid/rx_ready : incoming byte handshake
//   w_en/w_addr/instruction   : instruction memory write port
//   prog_ready/load_error/busy: load status towards the core
// master = the loader, slave = byte source / memory / core side.
interface program_loader_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  prog_ready;
    logic                  load_error;
    logic                  busy;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, w_en, w_addr, instruction, prog_ready, load_error, busy
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, w_en, w_addr, instruction, prog_ready, load_error, busy
    );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs payload bytes little-endian into a 32-bit word and keeps the running
// XOR checksum of every payload byte since the last clear.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : restart (new frame payload)
//   load       : accept byte_in at the current byte position
//   byte_in    : payload byte
//   word_next  : current word with byte_in merged at the current position
//   last_byte  : current position is the 4th byte of a word
//   checksum   : XOR of all payload bytes loaded since clear
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        last_byte,
    output logic [7:0]  checksum
);

    logic [31:0] word_q;
    logic [1:0]  byte_idx;

    always_comb begin
        word_next = word_q;
        case (byte_idx)
            2'd0:    word_next[7:0]   = byte_in;
            2'd1:    word_next[15:8]  = byte_in;
            2'd2:    word_next[23:16] = byte_in;
            default: word_next[31:24] = byte_in;
        endcase
    end

    assign last_byte = (byte_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_q   <= '0;
            byte_idx <= '0;
            checksum <= '0;
        end else if (load) begin
            word_q   <= word_next;
            byte_idx <= byte_idx + 2'd1;
            checksum <= checksum ^ byte_in;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: parses SYNC | LEN_LO | LEN_HI | LEN*4 payload | CHK frames
// from a byte stream and writes little-endian 32-bit words to instruction
// memory; flags a verified image (prog_ready) or a failed frame (load_error).
//   clk, rst : clock, synchronous active-high reset
//   bus      : program_loader_if.master (rx handshake, write port, status)
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_DEPTH      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic              clk,
    input logic              rst,
    program_loader_if.master bus
);

    localparam int unsigned CNT_W = $clog2(MEM_DEPTH + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    loader_state_t         state, state_next;
    logic [7:0]            len_lo;
    logic [CNT_W-1:0]      word_count;
    logic [CNT_W-1:0]      word_idx;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [DATA_WIDTH-1:0] w_addr_q;
    logic [DATA_WIDTH-1:0] instr_q;

    logic        rx_ready;
    logic        accept;
    logic        tmo_run;
    logic        tmo_hit;
    logic [15:0] len_full;
    logic        len_bad;
    logic        asm_clear;
    logic        asm_load;
    logic        asm_last;
    logic [31:0] asm_word;
    logic [7:0]  asm_chk;

    assign rx_ready = (state != WRITE);
    assign accept   = bus.rx_valid && rx_ready;
    assign tmo_run  = (state == LEN_LO) || (state == LEN_HI) ||
                      (state == DATA)   || (state == CHECK);
    // Timer counts idle cycles since the last accepted byte; the cycle that
    // would make it reach TIMEOUT_CYCLES sends the frame to ERROR.
    assign tmo_hit  = tmo_run && !accept && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Full 16-bit length is range-checked before it is narrowed to CNT_W.
    assign len_full = {bus.rx_data, len_lo};
    assign len_bad  = (len_full == 16'd0) || (len_full > 16'(MEM_DEPTH));

    assign asm_clear = (state == LEN_HI) && accept && !len_bad;
    assign asm_load  = (state == DATA) && accept;

    word_assembler u_word_assembler (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .load      (asm_load),
        .byte_in   (bus.rx_data),
        .word_next (asm_word),
        .last_byte (asm_last),
        .checksum  (asm_chk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len_lo     <= '0;
            word_count <= '0;
            word_idx   <= '0;
            tmo_cnt    <= '0;
            w_addr_q   <= '0;
            instr_q    <= '0;
        end else begin
            state <= state_next;
            if ((state == LEN_LO) && accept) begin
                len_lo <= bus.rx_data;
            end
            if (asm_clear) begin
                word_count <= CNT_W'(len_full);
                word_idx   <= '0;
            end
            // Address and data are captured with the 4th byte so they are
            // stable for the whole WRITE cycle and hold afterwards.
            if (asm_load && asm_last) begin
                w_addr_q <= DATA_WIDTH'(word_idx) << 2;
                instr_q  <= asm_word;
            end
            if (state == WRITE) begin
                word_idx <= word_idx + CNT_W'(1);
            end
            if (!tmo_run || accept) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (bus.rx_data == SYNC_BYTE)) state_next = LEN_LO;
            end
            LEN_LO: begin
                if (accept) state_next = LEN_HI;
            end
            LEN_HI: begin
                if (accept) state_next = len_bad ? ERROR : DATA;
            end
            DATA: begin
                if (accept && asm_last) state_next = WRITE;
            end
            WRITE: begin
                state_next = ((word_idx + CNT_W'(1)) == word_count) ? CHECK : DATA;
            end
            CHECK: begin
                if (accept) state_next = (bus.rx_data == asm_chk) ? DONE : ERROR;
            end
            DONE, ERROR: begin
                if (accept && (bus.rx_data == SYNC_BYTE)) state_next = LEN_LO;
            end
            default: state_next = IDLE;
        endcase
        if (tmo_hit) state_next = ERROR;
    end

    assign bus.rx_ready    = rx_ready;
    assign bus.w_en        = (state == WRITE);
    assign bus.w_addr      = w_addr_q;
    assign bus.instruction = instr_q;
    assign bus.prog_ready  = (state == DONE);
    assign bus.load_error  = (state == ERROR);
    assign bus.busy        = (state != IDLE) && (state != DONE) && (state != ERROR);

endmodule
